dbl_fetch_ctrl: RTL and testbench

DBL_FETCH_CTRL -- requirements
Module: dbl_fetch_ctrl

---
 rtl/dbl_fetch_ctrl_pkg.sv | 22 ++
 rtl/dbl_fetch_if.sv | 24 ++
 rtl/dbl_fetch_ctrl_fetch_timer.sv | 29 ++
 rtl/dbl_fetch_ctrl.sv | 68 ++++++
 tb/tb_dbl_fetch_ctrl.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/dbl_fetch_ctrl_pkg.sv
// Shared fetch-controller definitions: state encoding, opcode decode mask and
// default memory-wait limit, used by the controller and anything that decodes alongside it.
package dbl_fetch_ctrl_pkg;

  localparam int         DFLT_TIMEOUT       = 15;
  localparam logic [7:0] DFLT_TWO_BYTE_MASK = 8'h80;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_PC_INC,
    S_RD_WAIT,
    S_TR_LOAD,
    S_EXEC,
    S_FAULT
  } state_e;

  function automatic logic is_dbl(input logic [7:0] opc, input logic [7:0] mask);
    return |(opc & mask);
  endfunction

endpackage

// File: rtl/dbl_fetch_if.sv
// Handshake bundle between the fetch controller and the CPU core / memory side.
interface dbl_fetch_if;
  logic       start;
  logic [7:0] opcode;
  logic       mem_ready;
  logic       exec_done;
  logic       pcinc;
  logic       mem_rd;
  logic       trload;
  logic       tr_oe;
  logic       exec_go;
  logic       busy;
  logic       fault;

  modport master (
    output start, opcode, mem_ready, exec_done,
    input  pcinc, mem_rd, trload, tr_oe, exec_go, busy, fault
  );

  modport slave (
    input  start, opcode, mem_ready, exec_done,
    output pcinc, mem_rd, trload, tr_oe, exec_go, busy, fault
  );
endinterface

// File: rtl/dbl_fetch_ctrl_fetch_timer.sv
// Memory-wait counter: cleared while not waiting, counts wait cycles and flags
// the last permitted cycle so the controller can fault on the following edge.
module fetch_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = 8'h00;
    else if (en_i) cnt_d = cnt_q + 8'h01;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 8'h00;
    else     cnt_q <= cnt_d;
  end

  // Counter holds TIMEOUT-1 during the TIMEOUT-th wait cycle; never reaches 255.
  assign expired_o = en_i && (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/dbl_fetch_ctrl.sv
// Instruction fetch sequencer: single-byte opcodes go straight to execute,
// double-byte opcodes fetch one operand byte into TR first.
module dbl_fetch_ctrl
  import dbl_fetch_ctrl_pkg::*;
#(
  parameter int         TIMEOUT       = DFLT_TIMEOUT,
  parameter logic [7:0] TWO_BYTE_MASK = DFLT_TWO_BYTE_MASK
) (
  input  logic        clk,
  input  logic        rst,
  dbl_fetch_if.slave  bus
);

  state_e     state_q, state_d;
  logic [7:0] opc_q, opc_d;
  logic       dbl;
  logic       expired;

  assign dbl = is_dbl(opc_q, TWO_BYTE_MASK);

  fetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (state_q != S_RD_WAIT),
    .en_i      (state_q == S_RD_WAIT),
    .expired_o (expired)
  );

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    unique case (state_q)
      S_IDLE:    if (bus.start) begin
                   opc_d   = bus.opcode;
                   state_d = S_DECODE;
                 end
      S_DECODE:  state_d = dbl ? S_PC_INC : S_EXEC;
      S_PC_INC:  state_d = S_RD_WAIT;
      // mem_ready takes priority over an expiring wait in the same cycle
      S_RD_WAIT: if (bus.mem_ready) state_d = S_TR_LOAD;
                 else if (expired)  state_d = S_FAULT;
      S_TR_LOAD: state_d = S_EXEC;
      S_EXEC:    if (bus.exec_done) state_d = S_IDLE;
      S_FAULT:   state_d = S_FAULT;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      opc_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
    end
  end

  // Moore outputs: decoded from state and latched opcode only.
  assign bus.pcinc   = (state_q == S_PC_INC);
  assign bus.mem_rd  = (state_q == S_RD_WAIT);
  assign bus.trload  = (state_q == S_TR_LOAD);
  assign bus.exec_go = (state_q == S_TR_LOAD) || ((state_q == S_DECODE) && !dbl);
  assign bus.tr_oe   = (state_q == S_EXEC) && dbl;
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.fault   = (state_q == S_FAULT);

endmodule

// File: tb/tb_dbl_fetch_ctrl.sv
// Scoreboard bench for dbl_fetch_ctrl: stimulus queues expected pulse events,
// a negedge monitor pops and compares them; level checks are done inline.
module tb_dbl_fetch_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dbl_fetch_if bus();

  dbl_fetch_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // event vector: {pcinc, mem_rd, trload, exec_go, tr_oe, fault}
  localparam logic [5:0] EV_GO  = 6'b000100;
  localparam logic [5:0] EV_PC  = 6'b100000;
  localparam logic [5:0] EV_TL  = 6'b001100;
  localparam logic [5:0] EV_FLT = 6'b000001;

  int         errors = 0;
  int         checks = 0;
  int         rd_cycles = 0;
  int         rd0;
  logic [5:0] exp_q[$];
  logic [5:0] mon_e;
  logic       fault_prev = 1'b0;

  function automatic logic [5:0] ev_vec();
    return {bus.pcinc, bus.mem_rd, bus.trload, bus.exec_go, bus.tr_oe, bus.fault};
  endfunction

  // {pcinc, mem_rd, trload, exec_go, tr_oe, fault, busy}
  function automatic logic [6:0] outs();
    return {ev_vec(), bus.busy};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_instr(input logic [7:0] op);
    bus.opcode = op;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
  endtask

  // Monitor: every pulse (and the fault rising edge) must match the next queued event.
  initial forever begin
    @(negedge clk);
    if (bus.mem_rd) rd_cycles++;
    if (!rst && (bus.pcinc || bus.trload || bus.exec_go || (bus.fault && !fault_prev))) begin
      if (exp_q.size() == 0) chk("unexpected_event", 32'(ev_vec()), 32'h0);
      else begin
        mon_e = exp_q.pop_front();
        chk("event", 32'(ev_vec()), 32'(mon_e));
      end
    end
    fault_prev = bus.fault;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0; bus.opcode = 8'h00; bus.mem_ready = 1'b0; bus.exec_done = 1'b0;
    #12;
    chk("reset_outs", 32'(outs()), 32'h0);

    // single-byte, start accepted on first edge after reset release
    exp_q.push_back(EV_GO);
    rd0 = rd_cycles;
    bus.opcode = 8'h12; bus.start = 1'b1;
    rst = 1'b0;
    tick(); bus.start = 1'b0;
    chk("single_busy", 32'(bus.busy), 32'h1);
    tick();
    chk("single_exec_outs", 32'(outs()), 32'b0000001);
    bus.exec_done = 1'b1; tick(); bus.exec_done = 1'b0;
    chk("single_done_outs", 32'(outs()), 32'h0);
    chk("single_no_rd", 32'(rd_cycles - rd0), 32'h0);

    // double-byte, mem_ready 2 cycles into RD_WAIT, spurious exec_done/start
    exp_q.push_back(EV_PC);
    exp_q.push_back(EV_TL);
    rd0 = rd_cycles;
    start_instr(8'h85);
    chk("dbl_decode_outs", 32'(outs()), 32'b0000001);
    tick();                                // PC_INC
    tick();                                // RD_WAIT 1
    bus.exec_done = 1'b1; tick(); bus.exec_done = 1'b0;  // RD_WAIT 2
    chk("dbl_rdwait_outs", 32'(outs()), 32'b0100001);
    bus.mem_ready = 1'b1; tick(); bus.mem_ready = 1'b0;  // TR_LOAD
    tick();                                // EXEC
    chk("dbl_exec_outs", 32'(outs()), 32'b0000101);
    bus.opcode = 8'h12; bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("dbl_exec_hold", 32'(outs()), 32'b0000101);
    tick();
    bus.exec_done = 1'b1; tick(); bus.exec_done = 1'b0;
    chk("dbl_done_outs", 32'(outs()), 32'h0);
    chk("dbl_rd_cycles", 32'(rd_cycles - rd0), 32'd2);

    // timeout: no mem_ready, fault after 15 wait cycles, sticky
    exp_q.push_back(EV_PC);
    exp_q.push_back(EV_FLT);
    start_instr(8'h90);
    tick(); tick();                        // RD_WAIT 1
    ticks(14);                             // RD_WAIT 15
    chk("to_last_wait", 32'(outs()), 32'b0100001);
    tick();
    chk("to_fault", 32'(outs()), 32'b0000011);
    bus.opcode = 8'h12; bus.start = 1'b1; tick(); bus.start = 1'b0;
    ticks(3);
    chk("to_sticky", 32'(outs()), 32'b0000011);
    #2 rst = 1'b1;
    #1 chk("to_reset", 32'(outs()), 32'h0);
    #2 rst = 1'b0;

    // tie: mem_ready first seen on the 15th wait cycle
    exp_q.push_back(EV_PC);
    exp_q.push_back(EV_TL);
    start_instr(8'h85);
    tick(); tick();
    ticks(14);
    bus.mem_ready = 1'b1; tick(); bus.mem_ready = 1'b0;
    chk("tie_trload", 32'(outs()), 32'b0011001);
    tick();
    bus.exec_done = 1'b1; tick(); bus.exec_done = 1'b0;
    chk("tie_done_outs", 32'(outs()), 32'h0);

    // async reset mid RD_WAIT, then a normal single-byte instruction
    exp_q.push_back(EV_PC);
    start_instr(8'h81);
    tick(); tick(); tick();                // RD_WAIT 2
    #2 rst = 1'b1;
    #1 chk("async_rst_outs", 32'(outs()), 32'h0);
    #2;
    exp_q.push_back(EV_GO);
    bus.opcode = 8'h12; bus.start = 1'b1;
    rst = 1'b0;
    tick(); bus.start = 1'b0;
    chk("post_rst_busy", 32'(bus.busy), 32'h1);
    tick();
    bus.exec_done = 1'b1; tick(); bus.exec_done = 1'b0;
    chk("post_rst_done", 32'(outs()), 32'h0);

    ticks(2);
    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
